// File: rtl/logic_unit_mc.sv
// -----------------------------------------------------------------------------
// logic_unit_mc
//
// Multi-cycle logic unit for the ALU datapath. Bitwise operations (AND, OR,
// XOR, NOR, ANDN, XNOR and the reserved codes) complete in one cycle. POPCNT
// and CLZ walk the A operand CHUNK bits at a time, MSB slice first, and always
// take exactly N = WIDTH/CHUNK cycles. Both sides use a valid/ready handshake
// so the pipeline controller can stall on the unit.
//
// Parameters
//   WIDTH      operand/result width (must be a multiple of CHUNK)
//   CHUNK      bits examined per cycle by the iterative ops
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands and op code present
//   in_ready   unit can accept; transfer on in_valid && in_ready
//   a, b       operands (b unused by POPCNT/CLZ)
//   op         operation code: 0 AND, 1 OR, 2 XOR, 3 NOR, 4 ANDN, 5 XNOR,
//              6 POPCNT, 7 CLZ, 8-15 reserved (result 0)
//   out_valid  result/zero valid
//   out_ready  consumer accepts; transfer on out_valid && out_ready
//   result     registered result
//   zero       registered (result == 0)
//   busy       high while an iterative op is counting
// -----------------------------------------------------------------------------
module logic_unit_mc #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy
);

    // Number of slices, i.e. cycles spent in ITER.
    localparam int N     = WIDTH / CHUNK;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    // Accumulator must represent the value WIDTH itself (CLZ of zero).
    localparam int ACC_W = $clog2(WIDTH) + 1;
    // Per-slice count ranges 0..CHUNK.
    localparam int SL_W  = $clog2(CHUNK + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // State and datapath registers with their next-state values
    // -------------------------------------------------------------------------
    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_a;          // remaining operand, next slice at MSB
    logic [WIDTH-1:0]   w_a_next;
    logic               r_is_clz;     // 1: CLZ, 0: POPCNT
    logic               w_is_clz_next;
    logic [ACC_W-1:0]   r_acc;
    logic [ACC_W-1:0]   w_acc_next;
    logic [CNT_W-1:0]   r_cnt;        // slice index within ITER
    logic [CNT_W-1:0]   w_cnt_next;
    logic               r_seen;       // CLZ: a one has already been found
    logic               w_seen_next;
    logic [WIDTH-1:0]   r_result;
    logic [WIDTH-1:0]   w_result_next;
    logic               r_zero;
    logic               w_zero_next;

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------

    // The six bitwise encodings; any other code yields zero.
    function automatic logic [WIDTH-1:0] f_bitwise(
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y,
        input logic [3:0]       code
    );
        logic [WIDTH-1:0] r;
        r = '0;
        case (code)
            4'd0:    r = x & y;
            4'd1:    r = x | y;
            4'd2:    r = x ^ y;
            4'd3:    r = ~(x | y);
            4'd4:    r = x & ~y;
            4'd5:    r = ~(x ^ y);
            default: r = '0;
        endcase
        return r;
    endfunction

    // Number of ones in one slice.
    function automatic logic [SL_W-1:0] f_slice_ones(input logic [CHUNK-1:0] s);
        logic [SL_W-1:0] c;
        c = '0;
        for (int k = 0; k < CHUNK; k++) begin
            c = c + SL_W'(s[k]);
        end
        return c;
    endfunction

    // Leading zeros of one slice; CHUNK when the slice is all zero.
    function automatic logic [SL_W-1:0] f_slice_lz(input logic [CHUNK-1:0] s);
        logic [SL_W-1:0] c;
        logic            found;
        c     = '0;
        found = 1'b0;
        for (int k = CHUNK - 1; k >= 0; k--) begin
            if (!found) begin
                if (s[k]) begin
                    found = 1'b1;
                end else begin
                    c = c + SL_W'(1);
                end
            end
        end
        return c;
    endfunction

    // -------------------------------------------------------------------------
    // Combinational datapath
    // -------------------------------------------------------------------------
    logic [CHUNK-1:0]   w_slice;
    logic [SL_W-1:0]    w_slice_ones;
    logic [SL_W-1:0]    w_slice_lz;
    logic [SL_W-1:0]    w_step;
    logic [ACC_W-1:0]   w_acc_sum;
    logic [WIDTH-1:0]   w_bitwise;
    logic               w_iter_op;
    logic               w_can_take;
    logic               w_accept;

    assign w_slice      = r_a[WIDTH-1 -: CHUNK];
    assign w_slice_ones = f_slice_ones(w_slice);
    assign w_slice_lz   = f_slice_lz(w_slice);

    // CLZ stops accumulating once a one has been seen in an earlier slice;
    // the slice that contains the first one still contributes its own
    // leading-zero count.
    always_comb begin
        w_step = '0;
        if (r_is_clz) begin
            if (!r_seen) begin
                w_step = w_slice_lz;
            end
        end else begin
            w_step = w_slice_ones;
        end
    end

    assign w_acc_sum = r_acc + ACC_W'(w_step);
    assign w_bitwise = f_bitwise(a, b, op);
    assign w_iter_op = (op == 4'd6) || (op == 4'd7);

    // Free to take a new op when empty, or when the held result leaves in
    // this same cycle (back-to-back).
    assign w_can_take = (r_state == S_IDLE) || ((r_state == S_HOLD) && out_ready);
    assign in_ready   = rst_n && w_can_take;
    assign w_accept   = in_valid && in_ready;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next  = r_state;
        w_a_next      = r_a;
        w_is_clz_next = r_is_clz;
        w_acc_next    = r_acc;
        w_cnt_next    = r_cnt;
        w_seen_next   = r_seen;
        w_result_next = r_result;
        w_zero_next   = r_zero;

        case (r_state)
            S_IDLE, S_HOLD: begin
                if (w_accept) begin
                    if (w_iter_op) begin
                        w_state_next  = S_ITER;
                        w_a_next      = a;
                        w_is_clz_next = op[0];
                        w_acc_next    = '0;
                        w_cnt_next    = '0;
                        w_seen_next   = 1'b0;
                    end else begin
                        w_state_next  = S_HOLD;
                        w_result_next = w_bitwise;
                        w_zero_next   = (w_bitwise == '0);
                    end
                end else if ((r_state == S_HOLD) && out_ready) begin
                    w_state_next = S_IDLE;
                end
            end

            S_ITER: begin
                // Shift the next slice up to the MSB position.
                w_a_next    = r_a << CHUNK;
                w_acc_next  = w_acc_sum;
                w_seen_next = r_seen | (|w_slice);
                w_cnt_next  = r_cnt + CNT_W'(1);
                // Fixed latency: always finish after the last slice.
                if (r_cnt == CNT_W'(N - 1)) begin
                    w_state_next  = S_HOLD;
                    w_result_next = WIDTH'(w_acc_sum);
                    w_zero_next   = (w_acc_sum == '0);
                end
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_is_clz <= 1'b0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_seen   <= 1'b0;
            r_result <= '0;
            r_zero   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_a      <= w_a_next;
            r_is_clz <= w_is_clz_next;
            r_acc    <= w_acc_next;
            r_cnt    <= w_cnt_next;
            r_seen   <= w_seen_next;
            r_result <= w_result_next;
            r_zero   <= w_zero_next;
        end
    end

    assign out_valid = (r_state == S_HOLD);
    assign busy      = (r_state == S_ITER);
    assign result    = r_result;
    assign zero      = r_zero;

endmodule

// File: tb/tb_logic_unit_mc.sv
// -----------------------------------------------------------------------------
// tb_logic_unit_mc
//
// Directed bench for logic_unit_mc (WIDTH=32, CHUNK=8). A transaction-level
// model (countdown for iterative ops, a single output slot) predicts
// in_ready/out_valid/busy/result/zero every cycle. Each issued op also carries
// a hand-computed result, zero flag and latency that are checked when the
// result is presented and when it is consumed.
// -----------------------------------------------------------------------------
module tb_logic_unit_mc;

    localparam int W = 32;
    localparam int N = 4;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [3:0]    op;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic          zero;
    logic          busy;

    // Side-band literal expectation travelling with the issued op.
    logic          lit_valid;
    logic [W-1:0]  lit_res;
    logic          lit_zero;
    int            lit_lat;
    logic          done;

    logic_unit_mc #(.WIDTH(32), .CHUNK(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // -------------------------------------------------------------------------
    // Reference function: what an op must produce
    // -------------------------------------------------------------------------
    function automatic logic [W-1:0] model_f(input logic [3:0] o,
                                             input logic [W-1:0] x,
                                             input logic [W-1:0] y);
        int n;
        case (o)
            4'd0: return x & y;
            4'd1: return x | y;
            4'd2: return x ^ y;
            4'd3: return ~(x | y);
            4'd4: return x & ~y;
            4'd5: return ~(x ^ y);
            4'd6: return W'($countones(x));
            4'd7: begin
                n = 0;
                for (int i = W - 1; i >= 0; i--) begin
                    if (x[i]) break;
                    n++;
                end
                return W'(n);
            end
            default: return '0;
        endcase
    endfunction

    // -------------------------------------------------------------------------
    // Compare process: model + checks, evaluated mid-cycle
    // -------------------------------------------------------------------------
    typedef struct {
        logic [W-1:0] res;
        logic         z;
        int           lat;
    } lit_t;

    lit_t          lit_q[$];
    int            acc_q[$];
    int            n_vec = 0;
    int            n_err = 0;
    int            cyc = 0;
    int            busy_left = 0;
    bit            have_out = 0;
    bit            fresh = 0;
    logic [W-1:0]  out_val = '0;
    logic [W-1:0]  pend = '0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h required %h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        bit   exp_ir;
        bit   accept;
        lit_t l;
        int   t0;
        cyc++;
        if (done) begin
            chk("pending_literals", W'(lit_q.size()), W'(0));
            chk("end_out_valid", W'(out_valid), W'(0));
            $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
            $finish;
        end else if (!rst_n) begin
            chk("rst_in_ready", W'(in_ready), W'(0));
            chk("rst_out_valid", W'(out_valid), W'(0));
            chk("rst_busy", W'(busy), W'(0));
            chk("rst_result", result, W'(0));
            chk("rst_zero", W'(zero), W'(0));
            have_out  = 0;
            busy_left = 0;
            fresh     = 0;
            acc_q.delete();
        end else begin
            exp_ir = (busy_left == 0) && (!have_out || out_ready);
            chk("in_ready", W'(in_ready), W'(exp_ir));
            chk("out_valid", W'(out_valid), W'(have_out));
            chk("busy", W'(busy), W'(busy_left > 0));
            if (have_out) begin
                chk("result_model", result, out_val);
                chk("zero_model", W'(zero), W'(out_val == '0));
                if (fresh) begin
                    fresh = 0;
                    t0 = (acc_q.size() > 0) ? acc_q.pop_front() : -1000;
                    if (lit_q.size() > 0) begin
                        chk("latency", W'(cyc - t0), W'(lit_q[0].lat));
                    end else begin
                        chk("unexpected_output", W'(1), W'(0));
                    end
                end
                if (out_ready) begin
                    if (lit_q.size() > 0) begin
                        l = lit_q.pop_front();
                        $display("xfer cyc=%0d result=%h zero=%b", cyc, result, zero);
                        chk("result_literal", result, l.res);
                        chk("zero_literal", W'(zero), W'(l.z));
                    end else begin
                        chk("unexpected_xfer", W'(1), W'(0));
                    end
                end
            end

            // Advance the model across the coming rising edge.
            accept = in_valid && exp_ir;
            if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) begin
                    have_out = 1;
                    out_val  = pend;
                    fresh    = 1;
                end
            end else begin
                if (have_out && out_ready) have_out = 0;
                if (accept) begin
                    acc_q.push_back(cyc);
                    if (lit_valid) begin
                        l.res = lit_res;
                        l.z   = lit_zero;
                        l.lat = lit_lat;
                        lit_q.push_back(l);
                    end
                    if (op == 4'd6 || op == 4'd7) begin
                        busy_left = N;
                        pend      = model_f(op, a, b);
                    end else begin
                        have_out = 1;
                        out_val  = model_f(op, a, b);
                        fresh    = 1;
                    end
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] er, input logic ez, input int el);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        op        = o;
        a         = x;
        b         = y;
        lit_valid = 1'b1;
        lit_res   = er;
        lit_zero  = ez;
        lit_lat   = el;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        lit_valid = 1'b0;
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int i = 0; i < n; i++) begin
            in_valid  = 1'b0;
            lit_valid = 1'b0;
            out_ready = ordy;
            a         = $urandom;
            b         = $urandom;
            op        = 4'($urandom_range(0, 15));
            @(posedge clk);
            #1;
        end
    endtask

    logic [3:0]   bb_op  [8];
    logic [W-1:0] bb_a   [8];
    logic [W-1:0] bb_b   [8];
    logic [W-1:0] bb_exp [8];
    logic [W-1:0] sw_exp [6];
    logic [3:0]   it_op  [5];
    logic [W-1:0] it_a   [5];
    logic [W-1:0] it_exp [5];

    initial begin
        sw_exp = '{32'h00F0_1234, 32'hFFF0_FFFF, 32'hFF00_EDCB,
                   32'h000F_0000, 32'hF000_0000, 32'h00FF_1234};
        it_op  = '{4'd6, 4'd6, 4'd7, 4'd7, 4'd7};
        it_a   = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h0001_0000, 32'h0000_0000, 32'h8000_0000};
        it_exp = '{32'd32, 32'd0, 32'd15, 32'd32, 32'd0};
        bb_op  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd0, 4'd1};
        bb_a   = '{32'hFFFF_0000, 32'h0000_000F, 32'hAAAA_AAAA, 32'h0000_0000,
                   32'h1234_5678, 32'h0000_0000, 32'h8000_0001, 32'h0000_0000};
        bb_b   = '{32'hFF00_FF00, 32'h0000_00F0, 32'h5555_5555, 32'h0000_0000,
                   32'h1234_5678, 32'hFFFF_FFFF, 32'h0000_0001, 32'h8000_0000};
        bb_exp = '{32'hFF00_0000, 32'h0000_00FF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                   32'h0000_0000, 32'h0000_0000, 32'h0000_0001, 32'h8000_0000};

        done      = 1'b0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        op        = '0;
        lit_valid = 1'b0;
        lit_res   = '0;
        lit_zero  = 1'b0;
        lit_lat   = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2, 1'b1);

        // Bitwise sweep, one cycle latency each.
        for (int i = 0; i < 6; i++) begin
            issue(4'(i), 32'hF0F0_1234, 32'h0FF0_FFFF, sw_exp[i], 1'b0, 1);
            idle(1, 1'b1);
        end

        // Iterative ops, fixed latency of N+1.
        for (int i = 0; i < 5; i++) begin
            issue(it_op[i], it_a[i], 32'hDEAD_BEEF, it_exp[i], it_exp[i] == '0, N + 1);
            idle(6, 1'b1);
        end

        // Operands change during ITER with in_valid high: must be ignored.
        issue(4'd7, 32'h0000_0F00, 32'h0, 32'd20, 1'b0, N + 1);
        for (int i = 0; i < N; i++) begin
            in_valid = 1'b1;
            op       = 4'd6;
            a        = 32'hFFFF_FFFF;
            @(posedge clk);
            #1;
        end
        idle(3, 1'b1);

        // Backpressure, then a back-to-back accept as the stall releases.
        issue(4'd2, 32'h1234_5678, 32'hFFFF_0000, 32'hEDCB_5678, 1'b0, 1);
        idle(3, 1'b0);
        issue(4'd0, 32'hDEAD_BEEF, 32'h0F0F_0F0F, 32'h0E0D_0E0F, 1'b0, 1);
        idle(2, 1'b1);

        // Back-to-back stream of eight bitwise ops.
        for (int i = 0; i < 8; i++) begin
            issue(bb_op[i], bb_a[i], bb_b[i], bb_exp[i], bb_exp[i] == '0, 1);
        end
        idle(3, 1'b1);

        // Reserved op.
        issue(4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b1, 1);
        idle(2, 1'b1);

        // Reset during the second ITER cycle of CLZ(0xFF); nothing may emerge.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        op        = 4'd7;
        a         = 32'h0000_00FF;
        b         = 32'h0;
        lit_valid = 1'b0;
        @(posedge clk);
        #1;
        idle(1, 1'b1);
        rst_n = 1'b0;
        idle(1, 1'b1);
        rst_n = 1'b1;
        idle(8, 1'b1);

        // A normal op after the reset still works.
        issue(4'd1, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 1'b0, 1);
        idle(2, 1'b1);

        done = 1'b1;
        repeat (5) @(posedge clk);
        $display("FAIL summary: compare process did not finish");
        $fatal(1);
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
